// File: rtl/shift_job_sequencer.sv
// -----------------------------------------------------------------------------
// shift_job_sequencer
//
// Sequential controller that sits directly upstream of an 8-bit combinational
// barrel_shifter. The shifter does logical shifts with zero fill, takes a 3-bit
// amount, and uses dir 0 = left, 1 = right. The sequencer accepts a shift job
// whose total amount may exceed the shifter's 7-bit reach. It splits the job
// into passes of at most 7 bits each. The running value is kept in acc and fed
// through the shifter once per RUN cycle. The finished word is returned on a
// valid/ready response channel.
//
// Optional build macro:
//   EARLY_ZERO_EN - a job with req_amt >= DATA_W completes straight to DONE
//                   with a zero result, one edge after accept. The shifter is
//                   never driven with a nonzero amount for such a job.
//                   When the macro is undefined, these jobs take the normal
//                   multi-pass path and still yield zero.
//
// Every output is registered. Each one is loaded from the next-state values,
// so it always matches the state the FSM is in.
// -----------------------------------------------------------------------------
module shift_job_sequencer #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [AMT_W-1:0]  req_amt,
  input  logic              req_dir,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic [DATA_W-1:0] bs_data_in,
  output logic [2:0]        bs_shift_amt,
  output logic              bs_dir,
  input  logic [DATA_W-1:0] bs_data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest amount one shifter pass can apply.
  localparam logic [AMT_W-1:0] MAX_STEP = AMT_W'(7);

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_n;
  logic [AMT_W-1:0]  rem;
  logic [AMT_W-1:0]  rem_n;
  logic              dir_r;
  logic              dir_n;
  logic [2:0]        step;
  logic [2:0]        step_n;

  // Amount of the pass that is currently in flight (RUN).
  assign step   = (rem > MAX_STEP) ? 3'd7 : rem[2:0];
  // Amount of the pass the shifter will see next cycle, if the FSM is in RUN.
  assign step_n = (rem_n > MAX_STEP) ? 3'd7 : rem_n[2:0];

  // Next-state and next-datapath decode for the three-state job FSM.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_n = state;
    acc_n   = acc;
    rem_n   = rem;
    dir_n   = dir_r;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          acc_n = req_data;
          rem_n = req_amt;
          dir_n = req_dir;
          if (req_amt == '0) begin
            state_n = DONE;
          end
`ifdef EARLY_ZERO_EN
          else if (32'(req_amt) >= 32'(DATA_W)) begin
            // Every bit would be shifted out anyway, so skip the shifter.
            acc_n   = '0;
            rem_n   = '0;
            state_n = DONE;
          end
`endif
          else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        // rem never underflows here, because step is always <= rem.
        acc_n = bs_data_out;
        rem_n = rem - AMT_W'(step);
        if (rem <= MAX_STEP) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (resp_valid && resp_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs. A reset in the middle of a job
  // discards the job immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      rem          <= '0;
      dir_r        <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      busy         <= 1'b0;
      bs_data_in   <= '0;
      bs_shift_amt <= 3'd0;
      bs_dir       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      state        <= state_n;
      acc          <= acc_n;
      rem          <= rem_n;
      dir_r        <= dir_n;
      req_ready    <= (state_n == IDLE);
      resp_valid   <= (state_n == DONE);
      resp_data    <= (state_n == DONE) ? acc_n : '0;
      busy         <= (state_n != IDLE);
      // The shifter always sees acc, so no X ever reaches it. The amount and
      // direction are nonzero only while a pass is in flight.
      bs_data_in   <= acc_n;
      bs_shift_amt <= (state_n == RUN) ? step_n : 3'd0;
      bs_dir       <= (state_n == RUN) ? dir_n : 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_job_sequencer
//
// Directed bench for shift_job_sequencer, with a behavioural barrel_shifter
// attached to the bs_* ports. The stimulus thread pushes each job's expected
// result into a scoreboard queue. A separate monitor pops and compares an
// entry on every response handshake. Pass amounts, latency, backpressure and
// mid-job reset are checked inline by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_shift_job_sequencer;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic [AMT_W-1:0]  req_amt;
  logic              req_dir;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              busy;
  logic [DATA_W-1:0] bs_data_in;
  logic [2:0]        bs_shift_amt;
  logic              bs_dir;
  logic [DATA_W-1:0] bs_data_out;

  int n_vec  = 0;
  int n_miss = 0;

  logic [DATA_W-1:0] sb_q[$];

  shift_job_sequencer #(.DATA_W(DATA_W), .AMT_W(AMT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_amt      (req_amt),
    .req_dir      (req_dir),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .busy         (busy),
    .bs_data_in   (bs_data_in),
    .bs_shift_amt (bs_shift_amt),
    .bs_dir       (bs_dir),
    .bs_data_out  (bs_data_out)
  );

  // Behavioural barrel_shifter: logical shift, zero fill, dir 1 = right.
  assign bs_data_out = bs_dir ? (bs_data_in >> bs_shift_amt)
                              : (bs_data_in << bs_shift_amt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard pop per accepted response, sampled mid-cycle.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && resp_valid && resp_ready) begin
      logic [DATA_W-1:0] exp;
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      check("resp_data", 32'(resp_data), 32'(exp));
    end
  end

  // Runs one job and waits for its handshake. The latency and each RUN
  // pass's shifter drive are compared against an amount-splitting model.
  task automatic run_job(input logic [7:0] d, input logic [3:0] a, input logic dr,
                         input logic [7:0] exp, input int hold);
    int         lat;
    int         exp_lat;
    logic [3:0] r;
    logic [7:0] m;
    logic [2:0] st;
    bit         early;
    early = 1'b0;
`ifdef EARLY_ZERO_EN
    early = (a >= 4'd8);
`endif
    exp_lat = (a == 4'd0 || early) ? 1 : (int'(a) + 6) / 7 + 1;

    @(negedge clk);
    req_valid  = 1'b1;
    req_data   = d;
    req_amt    = a;
    req_dir    = dr;
    resp_ready = (hold == 0);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back(exp);
    @(negedge clk);
    // Scramble the request inputs; a running job must ignore them.
    req_valid = 1'b0;
    req_data  = ~d;
    req_amt   = ~a;
    req_dir   = ~dr;
    lat = 1;
    r   = a;
    m   = d;
    while (!resp_valid && lat < 40) begin
      st = (r > 4'd7) ? 3'd7 : r[2:0];
      check("run_shift_amt", 32'(bs_shift_amt), 32'(st));
      check("run_dir",       32'(bs_dir),       32'(dr));
      check("run_data_in",   32'(bs_data_in),   32'(m));
      check("run_req_ready", 32'(req_ready),    32'd0);
      m = dr ? (m >> st) : (m << st);
      r = r - 4'(st);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("done_shift_amt", 32'(bs_shift_amt), 32'd0);
    check("done_dir",       32'(bs_dir),       32'd0);
    for (int i = 0; i < hold; i++) begin
      check("bp_resp_data", 32'(resp_data), 32'(exp));
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy",      32'(busy),      32'd1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("idle_req_ready",  32'(req_ready),  32'd1);
    check("idle_resp_valid", 32'(resp_valid), 32'd0);
    check("idle_busy",       32'(busy),       32'd0);
    resp_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_data   = '0;
    req_amt    = '0;
    req_dir    = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready",    32'(req_ready),    32'd1);
    check("rst_resp_valid",   32'(resp_valid),   32'd0);
    check("rst_busy",         32'(busy),         32'd0);
    check("rst_resp_data",    32'(resp_data),    32'd0);
    check("rst_bs_shift_amt", 32'(bs_shift_amt), 32'd0);
    rst_n = 1'b1;

    run_job(8'b1011_0011, 4'd3,  1'b1, 8'b0001_0110, 0);  // single pass
    run_job(8'b1011_0011, 4'd9,  1'b0, 8'b0000_0000, 0);  // 7 then 2
    run_job(8'b1111_0000, 4'd0,  1'b0, 8'b1111_0000, 3);  // zero amount, backpressure
    run_job(8'b0000_0001, 4'd7,  1'b0, 8'b1000_0000, 0);  // exactly one full pass
    run_job(8'b1111_1111, 4'd15, 1'b1, 8'b0000_0000, 1);  // max amount, 7/7/1

    // Mid-job reset during the first RUN cycle.
    @(negedge clk);
    req_valid  = 1'b1;
    req_data   = 8'b1011_0011;
    req_amt    = 4'd14;
    req_dir    = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
`ifndef EARLY_ZERO_EN
    check("mid_run_shift_amt", 32'(bs_shift_amt), 32'd7);
`endif
    check("mid_run_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_req_ready",    32'(req_ready),    32'd1);
    check("mrst_resp_valid",   32'(resp_valid),   32'd0);
    check("mrst_busy",         32'(busy),         32'd0);
    check("mrst_resp_data",    32'(resp_data),    32'd0);
    check("mrst_bs_shift_amt", 32'(bs_shift_amt), 32'd0);
    check("mrst_bs_dir",       32'(bs_dir),       32'd0);
    check("mrst_bs_data_in",   32'(bs_data_in),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    resp_ready = 1'b0;
    run_job(8'b1011_0011, 4'd1, 1'b1, 8'b0101_1001, 0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
